// File: rtl/gray_codec_pkg.sv
// Shared types and stage-split helpers for the gray_codec pipeline.
package gray_codec_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } gc_mode_e;

  // Widest lane the stage record below can describe.
  localparam int GC_MAX_W = 64;

  typedef struct packed {
    logic                valid;
    gc_mode_e            mode;
    logic [GC_MAX_W-1:0] gray;
    logic [GC_MAX_W-1:0] bin;
  } gc_stage_t;

  typedef struct packed {
    logic     valid;
    gc_mode_e mode;
  } gc_ctl_t;

  function automatic int gc_chunk(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

  // Stages resolve bits MSB-first; trailing stages may get an empty range.
  function automatic int gc_bit_hi(input int w, input int s, input int idx);
    return w - 1 - idx * gc_chunk(w, s);
  endfunction

  function automatic int gc_bit_lo(input int w, input int s, input int idx);
    int lo;
    lo = gc_bit_hi(w, s, idx) - gc_chunk(w, s) + 1;
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One lane of one conversion stage: resolves binary bits BIT_HI..BIT_LO of a
// Gray word, or performs the whole binary->Gray step in the first stage.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BIT_HI     = 15,
  parameter int BIT_LO     = 12
) (
  input  gc_mode_e              mode_i,
  input  logic [DATA_WIDTH-1:0] gray_i,
  input  logic [DATA_WIDTH-1:0] bin_i,
  output logic [DATA_WIDTH-1:0] gray_o,
  output logic [DATA_WIDTH-1:0] bin_o
);

  localparam bit FIRST = (BIT_HI == DATA_WIDTH - 1);

  logic run;

  always_comb begin
    gray_o = gray_i;
    bin_o  = bin_i;
    run    = 1'b0;
    if (mode_i == MODE_G2B) begin
      // run carries the binary bit just above the current position.
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        if (i > BIT_HI) begin
          run = bin_i[i];
        end else if (i >= BIT_LO) begin
          run      = run ^ gray_i[i];
          bin_o[i] = run;
        end
      end
    end else if (FIRST) begin
      bin_o = gray_i ^ (gray_i >> 1);
    end
  end

endmodule

// File: rtl/gray_codec.sv
// Pipelined multi-lane Gray<->binary converter with valid/ready handshake.
// Optional transfer counter output enabled by macro GRAY_CODEC_WORD_CNT_EN.
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 1,
  parameter int STAGES     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic                            i_mode,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] i_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_mode,
  output logic [NUM_LANES*DATA_WIDTH-1:0] o_data
`ifdef GRAY_CODEC_WORD_CNT_EN
  ,
  output logic [31:0]                     o_word_cnt
`endif
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic    en;
  gc_ctl_t in_ctl_d;
  gc_ctl_t in_ctl_q;
  word_t   in_data_q [NUM_LANES];
  gc_ctl_t ctl_q     [STAGES];
  word_t   gray_q    [STAGES][NUM_LANES];
  word_t   bin_q     [STAGES][NUM_LANES];
  word_t   gray_d    [STAGES][NUM_LANES];
  word_t   bin_d     [STAGES][NUM_LANES];

  // The whole pipeline moves together whenever the output slot can drain.
  assign en       = !o_valid || i_ready;
  assign o_ready  = en && !rst;
  assign in_ctl_d = '{valid: i_valid && o_ready, mode: gc_mode_e'(i_mode)};

  // Input register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ctl_q <= '0;
      for (int k = 0; k < NUM_LANES; k++) in_data_q[k] <= '0;
    end else if (en) begin
      in_ctl_q <= in_ctl_d;
      for (int k = 0; k < NUM_LANES; k++) in_data_q[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Conversion stages
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      word_t    gray_in;
      word_t    bin_in;
      gc_mode_e mode_in;
      if (s == 0) begin : g_first
        assign gray_in = in_data_q[k];
        assign bin_in  = '0;
        assign mode_in = in_ctl_q.mode;
      end else begin : g_next
        assign gray_in = gray_q[s-1][k];
        assign bin_in  = bin_q[s-1][k];
        assign mode_in = ctl_q[s-1].mode;
      end
      gray_codec_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .BIT_HI    (gc_bit_hi(DATA_WIDTH, STAGES, s)),
        .BIT_LO    (gc_bit_lo(DATA_WIDTH, STAGES, s))
      ) u_stage (
        .mode_i(mode_in),
        .gray_i(gray_in),
        .bin_i (bin_in),
        .gray_o(gray_d[s][k]),
        .bin_o (bin_d[s][k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        ctl_q[s] <= '0;
        for (int k = 0; k < NUM_LANES; k++) begin
          gray_q[s][k] <= '0;
          bin_q[s][k]  <= '0;
        end
      end
    end else if (en) begin
      ctl_q[0] <= in_ctl_q;
      for (int s = 1; s < STAGES; s++) ctl_q[s] <= ctl_q[s-1];
      for (int s = 0; s < STAGES; s++) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          gray_q[s][k] <= gray_d[s][k];
          bin_q[s][k]  <= bin_d[s][k];
        end
      end
    end
  end

  // Output mapping
  assign o_valid = ctl_q[STAGES-1].valid;
  assign o_mode  = ctl_q[STAGES-1].mode;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_out
    assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = bin_q[STAGES-1][k];
  end

`ifdef GRAY_CODEC_WORD_CNT_EN
  logic [31:0] word_cnt_q;
  logic [31:0] word_cnt_d;

  assign word_cnt_d = word_cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else if (o_valid && i_ready) begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Randomized self-checking bench for gray_codec against a queue-based reference model.
module tb_gray_codec;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iv = 1'b0, ir = 1'b1, imode = 1'b0;
  logic [15:0] idata = '0;
  logic        ordy, ov, omode;
  logic [15:0] odata;

  logic        s_iv = 1'b0, s_ir = 1'b1, s_mode = 1'b0;
  logic [7:0]  s_idata = '0;
  logic        s_ordy, s_ov, s_omode;
  logic [7:0]  s_odata;
`ifdef GRAY_CODEC_WORD_CNT_EN
  logic [31:0] wcnt, s_wcnt;
`endif

  gray_codec u_dut (
    .clk(clk), .rst(rst), .i_valid(iv), .o_ready(ordy), .i_mode(imode), .i_data(idata),
    .o_valid(ov), .i_ready(ir), .o_mode(omode), .o_data(odata)
`ifdef GRAY_CODEC_WORD_CNT_EN
    , .o_word_cnt(wcnt)
`endif
  );

  gray_codec #(.DATA_WIDTH(4), .NUM_LANES(2), .STAGES(3)) u_small (
    .clk(clk), .rst(rst), .i_valid(s_iv), .o_ready(s_ordy), .i_mode(s_mode), .i_data(s_idata),
    .o_valid(s_ov), .i_ready(s_ir), .o_mode(s_omode), .o_data(s_odata)
`ifdef GRAY_CODEC_WORD_CNT_EN
    , .o_word_cnt(s_wcnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversions straight from the bit-level definitions.
  function automatic logic [15:0] ref_g2b(input logic [15:0] g);
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [15:0] ref_b2g(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  typedef struct packed {
    logic        mode;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          pop_cnt = 0;
  int          xfer_cnt = 0;
  logic        prev_rst = 1'b0, prev_stall = 1'b0, prev_mode = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      chk("rst_zero_valid", ov, 0);
      chk("rst_zero_data", odata, 0);
      chk("rst_zero_mode", omode, 0);
    end
    chk("o_ready_rule", ordy, (!ov || ir) && !rst);
    if (rst) begin
      exp_q.delete();
      xfer_cnt = 0;
    end else begin
      if (prev_stall && !prev_rst) begin
        chk("stall_valid", ov, 1);
        chk("stall_data", odata, prev_data);
        chk("stall_mode", omode, prev_mode);
      end
      if (ov && ir) begin
        pop_cnt++;
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word: got %h expected no word", odata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", odata, e.data);
          chk("out_mode", omode, e.mode);
        end
      end
      if (iv && ordy) begin
        e.mode = imode;
        e.data = imode ? ref_b2g(idata) : ref_g2b(idata);
        exp_q.push_back(e);
      end
    end
    prev_rst   = rst;
    prev_stall = ov && !ir && !rst;
    prev_data  = odata;
    prev_mode  = omode;
  end

  task automatic single(input logic m, input logic [15:0] d, input logic [15:0] expd, input string nm);
    int lat;
    @(posedge clk); #1 iv = 1'b1; imode = m; idata = d; ir = 1'b1;
    @(negedge clk); chk({nm, "_accept"}, ordy, 1);
    @(posedge clk); #1 iv = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ov) break;
    end
    chk({nm, "_latency"}, lat, 5);
    chk({nm, "_data"}, odata, expd);
    chk({nm, "_mode"}, omode, m);
  endtask

  task automatic xfer(input logic m, input logic [15:0] d, output logic [15:0] r);
    int n;
    @(posedge clk); #1 iv = 1'b1; imode = m; idata = d; ir = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ordy && n < 50);
    @(posedge clk); #1 iv = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov && n < 50);
    if (!ov) chk("xfer_timeout", 0, 1);
    r = odata;
  endtask

  task automatic drain(input string nm);
    int n;
    @(posedge clk); #1 iv = 1'b0; ir = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1 chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int          lat, base, seen;
    logic [15:0] v, g, r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", ov, 0);
    chk("reset_ready", ordy, 0);
    chk("reset_data", odata, 0);
    chk("reset_mode", omode, 0);
    @(posedge clk); #1 rst = 1'b0;

    single(1'b0, 16'h8000, 16'hFFFF, "g2b_8000");
    single(1'b1, 16'h00FF, 16'h0080, "b2g_00FF");

    // Two-lane narrow instance.
    @(posedge clk); #1 s_iv = 1'b1; s_mode = 1'b0; s_idata = {4'b1100, 4'b1011};
    @(negedge clk); chk("small_accept", s_ordy, 1);
    @(posedge clk); #1 s_iv = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (s_ov) break;
    end
    chk("small_latency", lat, 4);
    chk("small_data", s_odata, {4'b1000, 4'b1101});
    chk("small_mode", s_omode, 0);

    // Alternating modes under random backpressure.
    base = pop_cnt;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1 iv = 1'b1; imode = n[0]; idata = 16'($urandom); ir = 1'($urandom_range(0, 1));
      lat = 0;
      forever begin
        @(negedge clk);
        if (ordy || lat > 200) break;
        lat++;
        @(posedge clk); #1 ir = 1'($urandom_range(0, 1));
      end
      if (lat > 200) chk("bp_accept_timeout", 0, 1);
    end
    @(posedge clk); #1 iv = 1'b0;
    lat = 0;
    while ((pop_cnt - base) < 8 && lat < 400) begin
      @(posedge clk); #1 ir = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    chk("bp_count", pop_cnt - base, 8);
    drain("bp");

    // Reset with three words in flight.
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1 iv = 1'b1; ir = 1'b1; imode = n[0]; idata = 16'($urandom);
    end
    @(posedge clk); #1 iv = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("midrst_valid", ov, 0);
    base = pop_cnt;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov) seen++;
    end
    chk("midrst_stale", seen, 0);
    chk("midrst_pops", pop_cnt - base, 0);

    // Round trip through both directions.
    for (int n = 0; n < 16; n++) begin
      v = 16'($urandom);
      xfer(1'b1, v, g);
      xfer(1'b0, g, r);
      chk("roundtrip", r, v);
    end

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1
      iv = 1'($urandom_range(0, 1));
      imode = 1'($urandom_range(0, 1));
      idata = 16'($urandom);
      ir = ($urandom_range(0, 3) != 0);
    end
    drain("random");

`ifdef GRAY_CODEC_WORD_CNT_EN
    @(negedge clk); #1 chk("word_cnt", wcnt, xfer_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_codec.md
GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per lane word (>=2).
REQ-002 SHALL have parameter NUM_LANES, default 1: parallel lanes sharing one handshake.
REQ-003 SHALL have parameter STAGES, default 4: conversion pipeline stages (1..DATA_WIDTH).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1: input word valid.
REQ-007 SHALL have port o_ready, output, 1: block accepts input this cycle.
REQ-008 SHALL have port i_mode, input, 1: 0 = Gray->binary, 1 = binary->Gray; sampled per transfer.
REQ-009 SHALL have port i_data, input, NUM_LANES*DATA_WIDTH: lane k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port o_valid, output, 1: output word valid.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts output.
REQ-012 SHALL have port o_mode, output, 1: mode of the word on o_data.
REQ-013 SHALL have port o_data, output, NUM_LANES*DATA_WIDTH: converted lanes, same packing.

Function
REQ-014 SHALL convert Gray->binary as b[i] = XOR of g[DATA_WIDTH-1:i], per lane.
REQ-015 SHALL convert binary->Gray as g = b ^ (b >> 1), per lane.
REQ-016 SHALL split Gray->binary work MSB-first across STAGES stages, each resolving ceil(DATA_WIDTH/STAGES) bits; the last stage takes the remainder.
REQ-017 SHALL route binary->Gray words through the same stages, so latency is mode-independent.
REQ-018 SHALL register the input, then the STAGES stages. Latency i_valid&o_ready to o_valid is STAGES+1 cycles without backpressure.
REQ-019 SHALL carry a valid bit and mode bit per stage; mixed-mode words SHALL stay in order.
REQ-020 SHALL use pipeline enable en = !o_valid | i_ready. o_ready = en.
REQ-021 SHALL accept a transfer only when i_valid & o_ready.
REQ-022 SHALL hold o_data, o_mode and o_valid stable while o_valid & !i_ready.
REQ-023 SHALL sustain one word per cycle when i_valid and i_ready are held high.
REQ-024 SHALL advance bubbles (invalid stages) when en is high, without dropping any valid word.

Reset
REQ-025 SHALL clear all stage valid bits, data and mode to 0 on rst; o_valid=0, o_data=0, o_mode=0 on the cycle after rst is sampled high.
REQ-026 SHALL hold o_ready=0 while rst is high.
REQ-027 SHALL discard words in flight on reset mid-operation; no output appears for them.

Configuration
REQ-028 SHALL gate feature macro GRAY_CODEC_WORD_CNT_EN.
REQ-029 With GRAY_CODEC_WORD_CNT_EN defined, the block SHALL add output o_word_cnt (32 bits): it counts o_valid & i_ready transfers, wraps at 2^32, and is reset to 0.
REQ-030 Without GRAY_CODEC_WORD_CNT_EN, the block SHALL have no port and no counter logic.

Structure
REQ-031 SHALL place mode enum (MODE_G2B=0, MODE_B2G=1) and a per-stage struct typedef (valid, mode, gray, partial binary) in package gray_codec_pkg.
REQ-032 SHALL implement one stage as sub-module gray_codec_stage (params DATA_WIDTH, BIT_HI, BIT_LO), instantiated per stage and per lane by generate.

Verification
REQ-033 SHALL check with defaults, i_ready=1: mode 0, i_data 16'h8000 -> o_data 16'hFFFF exactly 5 cycles after transfer.
REQ-034 SHALL check with defaults: mode 1, i_data 16'h00FF -> o_data 16'h0080, o_mode=1.
REQ-035 SHALL check DATA_WIDTH=4, NUM_LANES=2, STAGES=3: lanes {4'b1100 Gray, 4'b1011 Gray}, mode 0 -> {4'b1000, 4'b1101}.
REQ-036 SHALL check backpressure: stream 8 alternating-mode words with random i_ready -> all 8 out in order, o_data held while stalled, no loss or duplication.
REQ-037 SHALL check reset mid-operation: 3 words in flight, rst pulsed 1 cycle -> o_valid=0 next cycle, no stale words emitted afterwards.
REQ-038 SHALL check round trip: random 16-bit values B2G then G2B -> original values; with GRAY_CODEC_WORD_CNT_EN, o_word_cnt equals the number of transfers.
